// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: parametrised UART receiver with mid-bit sampling and a one-entry valid/ready holding register.
// Parity checking is built only when the macro UART_RX_PARITY_EN is defined.
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 Rst,
  input  logic                 rx_sync,
  input  logic                 baud_tick,
  input  logic                 rx_enable,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 byte_rcv,
  output logic                 busy,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 overrun_error,
  input  logic                 err_clear
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [TW-1:0] TICK_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    DELIVER  = 3'd5,
    BRK_WAIT = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd4,
    DELIVER  = 3'd5,
    BRK_WAIT = 3'd6
  } state_t;
`endif

  state_t                 state_q, state_d;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   frame_err_q, frame_err_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   byte_rcv_q, byte_rcv_d;
  logic                   busy_q, busy_d;
  logic                   fe_q, fe_d;
  logic                   ov_q, ov_d;
  logic                   fe_ev, ov_ev, load_req;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = 1'(PARITY_ODD);
  logic                   pe_q, pe_d;
  logic                   pe_ev;
`else
  logic                   unused_parity_odd;
  assign unused_parity_odd = 1'(PARITY_ODD);
`endif

  // Frame sequencing, holding-register handshake and sticky flag next-state
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = frame_err_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    byte_rcv_d  = 1'b0;
    fe_ev       = 1'b0;
    ov_ev       = 1'b0;
    load_req    = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_ev       = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (rx_enable && !rx_sync) begin
          state_d     = START;
          tick_cnt_d  = TICK_ZERO;
          bit_cnt_d   = 4'd0;
          frame_err_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (baud_tick) begin
          if (tick_cnt_q == HALF_LAST) begin
            tick_cnt_d = TICK_ZERO;
            // A high sample at mid-start is a glitch, not a frame
            if (!rx_sync) begin
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = TICK_ZERO;
            shift_d    = {rx_sync, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_d = 4'd0;
`ifdef UART_RX_PARITY_EN
              state_d   = PARITY;
`else
              state_d   = STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = TICK_ZERO;
            bit_cnt_d  = 4'd0;
            state_d    = STOP;
            if (rx_sync != ((^shift_q) ^ PAR_ODD)) begin
              pe_ev = 1'b1;
            end else begin
              pe_ev = 1'b0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = TICK_ZERO;
            if (bit_cnt_q == STOP_LAST) begin
              bit_cnt_d = 4'd0;
              state_d   = DELIVER;
              // Delivery is decided on the last stop sample so rx_valid rises with DELIVER
              if (frame_err_q || !rx_sync) begin
                fe_ev       = 1'b1;
                frame_err_d = 1'b1;
              end else begin
                load_req    = 1'b1;
              end
            end else begin
              bit_cnt_d   = bit_cnt_q + 4'd1;
              frame_err_d = frame_err_q | ~rx_sync;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      DELIVER: begin
        if (frame_err_q) begin
          state_d = BRK_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      BRK_WAIT: begin
        if (rx_sync) begin
          state_d = IDLE;
        end else begin
          state_d = BRK_WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_req) begin
      if (rx_valid_q && !rx_ready) begin
        ov_ev = 1'b1;
      end else begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
        byte_rcv_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    busy_d = (state_d != IDLE);
    fe_d   = (fe_q & ~err_clear) | fe_ev;
    ov_d   = (ov_q & ~err_clear) | ov_ev;
`ifdef UART_RX_PARITY_EN
    pe_d   = (pe_q & ~err_clear) | pe_ev;
`endif
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      tick_cnt_q  <= TICK_ZERO;
      bit_cnt_q   <= 4'd0;
      shift_q     <= {DATA_BITS{1'b0}};
      frame_err_q <= 1'b0;
      rx_data_q   <= {DATA_BITS{1'b0}};
      rx_valid_q  <= 1'b0;
      byte_rcv_q  <= 1'b0;
      busy_q      <= 1'b0;
      fe_q        <= 1'b0;
      ov_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      byte_rcv_q  <= byte_rcv_d;
      busy_q      <= busy_d;
      fe_q        <= fe_d;
      ov_q        <= ov_d;
`ifdef UART_RX_PARITY_EN
      pe_q        <= pe_d;
`endif
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign byte_rcv      = byte_rcv_q;
  assign busy          = busy_q;
  assign framing_error = fe_q;
  assign overrun_error = ov_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error  = pe_q;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl: default 8N1 instance plus a 5-bit, 2-stop instance.
module tb_uart_rx_ctrl;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic Rst, rx_sync, rx2_sync, baud_tick, rx_enable, rx_ready, rx2_ready, err_clear;
  logic [7:0] rx_data;
  logic       rx_valid, byte_rcv, busy, fe, pe, ov;
  logic [4:0] rx2_data;
  logic       rx2_valid, byte2_rcv, busy2, fe2, pe2, ov2;

  int n_cmp = 0;
  int n_mis = 0;
  int n_b1  = 0;
  int n_b2  = 0;
  int base;

  uart_rx_ctrl dut1 (
    .clk(clk), .Rst(Rst), .rx_sync(rx_sync), .baud_tick(baud_tick),
    .rx_enable(rx_enable), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .byte_rcv(byte_rcv), .busy(busy),
    .framing_error(fe), .parity_error(pe), .overrun_error(ov),
    .err_clear(err_clear)
  );

  uart_rx_ctrl #(.DATA_BITS(5), .OVERSAMPLE(16), .STOP_BITS(2), .PARITY_ODD(0)) dut2 (
    .clk(clk), .Rst(Rst), .rx_sync(rx2_sync), .baud_tick(baud_tick),
    .rx_enable(rx_enable), .rx_ready(rx2_ready), .rx_data(rx2_data),
    .rx_valid(rx2_valid), .byte_rcv(byte2_rcv), .busy(busy2),
    .framing_error(fe2), .parity_error(pe2), .overrun_error(ov2),
    .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  // One baud tick every fourth clock
  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (byte_rcv)  n_b1 <= n_b1 + 1;
    if (byte2_rcv) n_b2 <= n_b2 + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_sync = v;
    else          rx2_sync = v;
  endtask

  task automatic send_bit(input int sel, input logic b);
    @(negedge clk);
    set_line(sel, b);
    wait_ticks(16);
  endtask

  task automatic send_frame(input int sel, input int nbits, input logic [8:0] data,
                            input logic par, input logic [1:0] stop, input int nstop,
                            input bit idle_after);
    send_bit(sel, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(sel, data[i]);
    if (PAR_EN) send_bit(sel, par);
    for (int i = 0; i < nstop; i++) send_bit(sel, stop[i]);
    if (idle_after) begin
      @(negedge clk);
      set_line(sel, 1'b1);
      wait_ticks(2);
    end
    @(negedge clk);
  endtask

  task automatic send_good(input int sel, input int nbits, input logic [8:0] data, input int nstop);
    send_frame(sel, nbits, data, ^data, 2'b11, nstop, 1'b1);
  endtask

  task automatic pulse_ready1();
    @(negedge clk); rx_ready = 1'b1;
    @(negedge clk); rx_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); err_clear = 1'b1;
    @(negedge clk); err_clear = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; rx_sync = 1'b1; rx2_sync = 1'b1; rx_enable = 1'b1;
    rx_ready = 1'b0; rx2_ready = 1'b0; err_clear = 1'b0;
    repeat (3) @(negedge clk);
    Rst = 1'b0;
    @(negedge clk);

    // reset state
    check_eq("rst_data", rx_data, 32'h0);
    check_eq("rst_valid", rx_valid, 32'h0);
    check_eq("rst_busy", busy, 32'h0);
    check_eq("rst_flags", {fe, pe, ov}, 32'h0);
    check_eq("rst_brcv", byte_rcv, 32'h0);

    // 1: 0xA5 into empty holding register
    base = n_b1;
    send_good(0, 8, 9'h0A5, 1);
    check_eq("t1_data", rx_data, 32'hA5);
    check_eq("t1_valid", rx_valid, 32'h1);
    check_eq("t1_brcv_cnt", n_b1 - base, 32'h1);
    check_eq("t1_flags", {fe, pe, ov}, 32'h0);
    check_eq("t1_busy", busy, 32'h0);
    pulse_ready1();
    check_eq("t1_consumed", rx_valid, 32'h0);
    check_eq("t1_data_hold", rx_data, 32'hA5);

    // rx_enable low ignores a low line
    rx_enable = 1'b0;
    @(negedge clk); rx_sync = 1'b0;
    wait_ticks(12);
    @(negedge clk);
    check_eq("en_off_busy", busy, 32'h0);
    rx_sync = 1'b1;
    rx_enable = 1'b1;
    wait_ticks(2);

    // 2: start glitch of 4 ticks
    base = n_b1;
    @(negedge clk); rx_sync = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    check_eq("t2_busy_start", busy, 32'h1);
    rx_sync = 1'b1;
    wait_ticks(20);
    @(negedge clk);
    check_eq("t2_busy_idle", busy, 32'h0);
    check_eq("t2_valid", rx_valid, 32'h0);
    check_eq("t2_flags", {fe, pe, ov}, 32'h0);
    check_eq("t2_brcv_cnt", n_b1 - base, 32'h0);

    // 3: bad stop bit then held-low break
    base = n_b1;
    send_frame(0, 8, 9'h03C, ^(9'h03C), 2'b00, 1, 1'b0);
    wait_ticks(40);
    @(negedge clk);
    check_eq("t3_fe", fe, 32'h1);
    check_eq("t3_valid", rx_valid, 32'h0);
    check_eq("t3_busy_brk", busy, 32'h1);
    check_eq("t3_brcv_cnt", n_b1 - base, 32'h0);
    rx_sync = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t3_busy_idle", busy, 32'h0);
    pulse_clear();
    check_eq("t3_fe_clr", fe, 32'h0);

    // 4: overrun, then delivery with rx_ready high
    base = n_b1;
    send_good(0, 8, 9'h012, 1);
    send_good(0, 8, 9'h034, 1);
    check_eq("t4_data_old", rx_data, 32'h12);
    check_eq("t4_ov", ov, 32'h1);
    check_eq("t4_brcv_cnt", n_b1 - base, 32'h1);
    pulse_ready1();
    check_eq("t4_consumed", rx_valid, 32'h0);
    pulse_clear();
    check_eq("t4_ov_clr", ov, 32'h0);
    base = n_b1;
    rx_ready = 1'b1;
    send_good(0, 8, 9'h056, 1);
    check_eq("t4_data_new", rx_data, 32'h56);
    check_eq("t4_no_ov", ov, 32'h0);
    check_eq("t4_brcv_new", n_b1 - base, 32'h1);
    check_eq("t4_valid_taken", rx_valid, 32'h0);
    rx_ready = 1'b0;

    // 5: even parity on 0x07 (expected parity bit 1)
    if (PAR_EN) begin
      base = n_b1;
      send_frame(0, 8, 9'h007, 1'b0, 2'b11, 1, 1'b1);
      check_eq("t5_data", rx_data, 32'h07);
      check_eq("t5_pe", pe, 32'h1);
      check_eq("t5_brcv", n_b1 - base, 32'h1);
      pulse_ready1();
      pulse_clear();
      check_eq("t5_pe_clr", pe, 32'h0);
      send_frame(0, 8, 9'h007, 1'b1, 2'b11, 1, 1'b1);
      check_eq("t5_pe_good", pe, 32'h0);
      check_eq("t5_valid", rx_valid, 32'h1);
    end else begin
      check_eq("t5_pe_tied", pe, 32'h0);
    end

    // 6: 5 data bits, 2 stop bits; reset mid-frame
    send_good(1, 5, 9'h00A, 2);
    check_eq("t6_pre_data", rx2_data, 32'h0A);
    check_eq("t6_pre_valid", rx2_valid, 32'h1);
    send_bit(1, 1'b0);
    send_bit(1, 1'b1);
    send_bit(1, 1'b0);
    send_bit(1, 1'b1);
    @(negedge clk); rx2_sync = 1'b0;
    wait_ticks(8);
    @(negedge clk);
    check_eq("t6_busy_mid", busy2, 32'h1);
    Rst = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_data", rx2_data, 32'h0);
    check_eq("t6_rst_ctl", {rx2_valid, byte2_rcv, busy2}, 32'h0);
    check_eq("t6_rst_flags", {fe2, pe2, ov2}, 32'h0);
    check_eq("t6_rst_dut1", {rx_data, rx_valid}, 32'h0);
    Rst = 1'b0;
    rx2_sync = 1'b1;
    wait_ticks(4);
    base = n_b2;
    send_good(1, 5, 9'h015, 2);
    check_eq("t6_data", rx2_data, 32'h15);
    check_eq("t6_valid", rx2_valid, 32'h1);
    check_eq("t6_fe0", fe2, 32'h0);
    check_eq("t6_brcv", n_b2 - base, 32'h1);
    send_frame(1, 5, 9'h00B, ^(9'h00B), 2'b01, 2, 1'b1);
    check_eq("t6_fe_stop2", fe2, 32'h1);
    check_eq("t6_data_kept", rx2_data, 32'h15);
    check_eq("t6_no_ov", ov2, 32'h0);
    check_eq("t6_brcv_bad", n_b2 - base, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Parametrised UART receive controller that replaces the fixed 8-bit rcu. Takes an already-synchronised serial line and an oversample tick, and performs start validation, mid-bit sampling and shifting of DATA_BITS, optional parity, and 1 or 2 stop-bit checks. Delivers bytes through a one-entry valid/ready holding register, with sticky framing, parity and overrun status. Sits between the rx synchroniser and the debugger command decoder.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5-9; sent LSB first.
OVERSAMPLE, 16, baud_tick pulses per bit; even, at least 4.
STOP_BITS, 1, stop bits checked; 1 or 2.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only with UART_RX_PARITY_EN.

Ports:
clk  in  1  system clock
Rst  in  1  synchronous reset, active-high
rx_sync  in  1  synchronised serial input; idle high
baud_tick  in  1  one-cycle pulse, OVERSAMPLE per bit time
rx_enable  in  1  permits start detection while in IDLE
rx_ready  in  1  consumer accepts rx_data
rx_data  out  DATA_BITS  received word (holding register)
rx_valid  out  1  holding register full
byte_rcv  out  1  one-cycle pulse per good frame loaded
busy  out  1  high in any state other than IDLE
framing_error  out  1  sticky
parity_error  out  1  sticky
overrun_error  out  1  sticky
err_clear  in  1  clears all three sticky flags

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (Rst). On reset the state is IDLE, the tick counter and bit counter are 0, and every output is 0, including rx_data.
- States: IDLE, START, DATA, PARITY, STOP, DELIVER, BRK_WAIT.
- IDLE: when rx_enable=1 and rx_sync=0, go to START and clear the tick counter.
- START: count baud_ticks. On tick OVERSAMPLE/2, sample rx_sync.
  - Sample 0: go to DATA and clear the counter.
  - Sample 1 (glitch): go back to IDLE with no flags set.
- DATA: sample on every OVERSAMPLE-th tick, which lands at mid-bit. Shift right into the shift register (LSB first). After DATA_BITS samples, go to PARITY if the macro is defined, otherwise go to STOP.
- PARITY: sample one bit as described under Optional Feature, then go to STOP.
- STOP: sample STOP_BITS bits at OVERSAMPLE-tick spacing.
  - Any sampled 0 sets framing_error.
  - Then go to DELIVER.
- DELIVER (exactly one cycle):
  - Frame good: load the holding register (see load rules), pulse byte_rcv, go to IDLE.
  - Framing error: discard the word, no rx_valid, no byte_rcv, go to BRK_WAIT.
- BRK_WAIT: stay until rx_sync=1, then go to IDLE. This stops a held-low break from retriggering.
- Latency: rx_valid and byte_rcv assert the cycle after the clk edge that samples the last stop bit.
- Holding register load rules:
  - rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle: load the new word, rx_valid stays or goes 1, no overrun.
  - rx_valid=1 with rx_ready=0: keep the old word, drop the new one, set overrun_error, do not pulse byte_rcv.
- Handshake: a transfer happens on a cycle with rx_valid=1 and rx_ready=1. rx_valid clears on the next edge unless a load happens in the same cycle. rx_data is stable while rx_valid=1.
- rx_enable deasserted mid-frame: the current frame completes. It gates only new start detection.
- Sticky flags:
  - Cleared by err_clear.
  - If err_clear and a new error event occur in the same cycle, the flag ends set.
  - Flags never block reception.
- baud_tick outside START, DATA, PARITY and STOP is ignored. Counters wrap to 0 after each sample.
- Rst asserted mid-frame: return to IDLE immediately. Any partial word is lost.

Optional Feature:
Macro: UART_RX_PARITY_EN
- Defined: the PARITY state exists and samples one bit after the data bits. The expected value is the XOR of the data bits, inverted when PARITY_ODD=1. A mismatch sets parity_error. The word is still delivered, and byte_rcv still pulses.
- Undefined: the PARITY state is absent, the frame is start + DATA_BITS + stop, and parity_error is tied 0. The port list is unchanged.

Test Plan:
1. Defaults; send 0xA5 with 1 stop bit and rx_ready=0 -> rx_data=0xA5, rx_valid=1, one byte_rcv pulse, all flags 0, busy=0 after DELIVER.
2. Pull rx_sync low for 4 ticks, then high -> START aborts at tick 8, back to IDLE, no rx_valid, no flags.
3. Send 0x3C with stop bit=0, then hold the line low 40 ticks -> framing_error=1, no rx_valid, FSM stays in BRK_WAIT until the line goes high; err_clear then drops the flag.
4. Send 0x12 then 0x34 with rx_ready=0 -> rx_data=0x12, overrun_error=1. Raise rx_ready for 1 cycle -> rx_valid=0. Send 0x56 with rx_ready=1 on the DELIVER cycle -> rx_data=0x56, no new overrun.
5. With UART_RX_PARITY_EN, PARITY_ODD=0, send 0x07 with parity bit 0 -> rx_data=0x07, parity_error=1. Send 0x07 with parity bit 1 -> no new error.
6. DATA_BITS=5, STOP_BITS=2: assert Rst at data bit 3 -> all outputs 0. Then send 0x15 -> rx_data=0x15. A second stop bit of 0 -> framing_error=1.
